// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine: FSM state encoding and
// the default data/index widths.
package reg_dump_pkg;

  localparam int DEFAULT_W = 8;
  localparam int DEFAULT_D = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } dump_state_t;

  // Occupancy after one cycle of a two-slot buffer.
  function automatic logic [1:0] level_after(input logic [1:0] level,
                                             input logic        push,
                                             input logic        pop);
    logic [1:0] result;
    result = level;
    if (push && !pop) result = level + 2'd1;
    else if (!push && pop) result = level - 2'd1;
    return result;
  endfunction

endpackage

// File: rtl/reg_dump_fifo.sv
// dump_fifo: two-slot circular buffer. The head slot is read straight from
// its register, so the head stays still until it is popped.
module dump_fifo
  import reg_dump_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       level_reg;
  logic             do_push;
  logic             do_pop;
  logic [1:0]       slot_we;

  assign empty = (level_reg == 2'd0);
  assign full  = (level_reg == 2'd2);

  // A push into a full buffer is only taken when the head leaves the same
  // cycle; the freed slot is exactly the one wr_ptr points at.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot_we
      assign slot_we[gi] = do_push && (wr_ptr_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (slot_we[i]) mem_reg[i] <= push_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      level_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      level_reg <= level_after(level_reg, do_push, do_pop);
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/reg_dump.sv
// reg_dump: walks a window of a register file and streams {index, value}
// entries through a ready/valid port. Define REG_DUMP_PARITY_EN to add an
// even-parity bit stored alongside each entry (out_parity).
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int D = DEFAULT_D
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  input  logic [D-1:0] first_index,
  input  logic [D:0]   count,
  output logic [D-1:0] reg_index,
  input  logic [W-1:0] Reg_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_index,
`ifdef REG_DUMP_PARITY_EN
  output logic         out_parity,
`endif
  output logic         Busy,
  output logic         Done
);

`ifdef REG_DUMP_PARITY_EN
  localparam int EW = W + D + 1;
`else
  localparam int EW = W + D;
`endif

  dump_state_t state_reg, state_next;
  logic [D-1:0] cur_index_reg, cur_index_next;
  logic [D:0]   remaining_reg, remaining_next;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;

  assign pop = out_valid && out_ready;

`ifdef REG_DUMP_PARITY_EN
  assign push_entry = {^Reg_out, Reg_out, cur_index_reg};
  assign out_parity = head_entry[W+D];
`else
  assign push_entry = {Reg_out, cur_index_reg};
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg     <= IDLE;
      cur_index_reg <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cur_index_reg <= cur_index_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_index_next = cur_index_reg;
    remaining_next = remaining_reg;
    push           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          remaining_next = count;
          if (count != '0) begin
            cur_index_next = first_index;
            state_next     = SCAN;
          end else begin
            state_next = FINISH;
          end
        end
      end
      SCAN: begin
        if (!fifo_full || pop) begin
          push           = 1'b1;
          remaining_next = remaining_reg - (D+1)'(1);
          // The index is left on the last read rather than stepping past it.
          if (remaining_reg == (D+1)'(1)) state_next = DRAIN;
          else cur_index_next = cur_index_reg + D'(1);
        end
      end
      DRAIN: begin
        if (fifo_empty) state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  dump_fifo #(
    .WIDTH(EW)
  ) u_fifo (
    .CLK      (CLK),
    .Reset    (Reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head_data(head_entry),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign reg_index = cur_index_reg;
  assign out_valid = !fifo_empty;
  assign out_data  = head_entry[W+D-1:D];
  assign out_index = head_entry[D-1:0];
  assign Busy      = (state_reg != IDLE);
  assign Done      = (state_reg == FINISH);

endmodule
